encoder_bank: RTL and testbench

Parametrised multi-channel quadrature rotary-encoder front end. It replaces the single-channel 8-bit encoder and drives the colour-mixer PWM channels. Each channel has input synchronisation, a glitch filter, X1/X2/X4 decoding, illegal-transition detection and a wrap or saturate position counter. Outputs feed the PWM duty inputs and status logic directly.

---
 rtl/encoder_pkg.sv | 47 ++++
 rtl/encoder_channel.sv | 169 ++++++++++++++++
 rtl/encoder_bank.sv | 52 +++++
 tb/tb_encoder_bank.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encoder_pkg
// Description : Shared decode-mode constants and quadrature transition
//               classification for the encoder bank.
// Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

  localparam logic [1:0] ENC_X1 = 2'b00;
  localparam logic [1:0] ENC_X2 = 2'b01;
  localparam logic [1:0] ENC_X4 = 2'b10;

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_UP      = 2'd1,
    TR_DOWN    = 2'd2,
    TR_ILLEGAL = 2'd3
  } trans_t;

  // Position of {A,B} along the CW sequence 00 -> 10 -> 11 -> 01
  function automatic logic [1:0] quad_index(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] curr);
    logic [1:0] diff;
    trans_t     kind;
    diff = quad_index(curr) - quad_index(prev);
    case (diff)
      2'd0:    kind = TR_NONE;
      2'd1:    kind = TR_UP;
      2'd3:    kind = TR_DOWN;
      default: kind = TR_ILLEGAL;
    endcase
    return kind;
  endfunction

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/encoder_channel.sv
`default_nettype none
// ============================================================================
// Module      : encoder_channel
// Description : One quadrature channel: synchroniser, glitch filter, priming,
//               X1/X2/X4 decode, wrap/saturate counter and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_channel
  import encoder_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       mode,
  input  logic             saturate,
  input  logic             clear,
  input  logic             error_clr,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             error
);

  localparam int              FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] C_FILL_DONE = FILL_W'(SYNC_STAGES);
  localparam logic [WIDTH-1:0]  C_MAX       = {WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [FILL_W-1:0]      r_fill;
  logic                   r_primed;
  logic [1:0]             r_prev;
  logic [WIDTH-1:0]       r_value;
  logic                   r_step;
  logic                   r_dir;
  logic                   r_error;

  logic [1:0]       w_synced;
  logic [1:0]       w_accepted;
  logic             w_sync_valid;
  trans_t           w_trans;
  logic             w_count;
  logic             w_up;
  logic             w_illegal;
  logic [WIDTH-1:0] w_next_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], a};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], b};
    end
  end

  assign w_synced     = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
  // Priming waits until the synchroniser holds real pin levels, so an idle 11
  // at power-up is loaded as the start state instead of seen as a 00->11 jump.
  assign w_sync_valid = (r_fill == C_FILL_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill <= '0;
    end else if (!w_sync_valid) begin
      r_fill <= r_fill + 1'b1;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_pin
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign w_accepted[p] = w_synced[p];
    end else begin : g_filter
      localparam int                CNT_W    = $clog2(FILTER_CYCLES + 1);
      localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
      logic             r_acc;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_acc <= 1'b0;
          r_cnt <= '0;
        end else if (!r_primed) begin
          r_acc <= w_synced[p];
          r_cnt <= '0;
        end else if (w_synced[p] == r_acc) begin
          r_cnt <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
          r_acc <= w_synced[p];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_accepted[p] = r_acc;
    end
  end

  assign w_trans   = classify(r_prev, w_accepted);
  assign w_illegal = r_primed && (w_trans == TR_ILLEGAL);

  always_comb begin
    w_count = 1'b0;
    w_up    = (w_trans == TR_UP);
    if (r_primed && (w_trans == TR_UP || w_trans == TR_DOWN)) begin
      case (mode)
        ENC_X1:  w_count = w_up ? (r_prev == 2'b00 && w_accepted == 2'b10)
                                : (r_prev == 2'b10 && w_accepted == 2'b00);
        ENC_X2:  w_count = r_prev[1] ^ w_accepted[1];
        default: w_count = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_next_value = r_value;
    if (w_up) begin
      if (!(saturate && r_value == C_MAX)) w_next_value = r_value + 1'b1;
    end else begin
      if (!(saturate && r_value == '0)) w_next_value = r_value - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_primed <= 1'b0;
      r_prev   <= 2'b00;
      r_value  <= '0;
      r_step   <= 1'b0;
      r_dir    <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (!r_primed) begin
        r_primed <= w_sync_valid;
        r_prev   <= w_synced;
      end else begin
        r_prev <= w_accepted;
      end

      r_step <= w_count;
      if (w_count) r_dir <= w_up;

      if (clear) begin
        r_value <= '0;
      end else if (w_count) begin
        r_value <= w_next_value;
      end

      if (w_illegal) begin
        r_error <= 1'b1;
      end else if (error_clr) begin
        r_error <= 1'b0;
      end
    end
  end

  assign value = r_value;
  assign step  = r_step;
  assign dir   = r_dir;
  assign error = r_error;

endmodule : encoder_channel
`default_nettype wire

// File: rtl/encoder_bank.sv
`default_nettype none
// ============================================================================
// Module      : encoder_bank
// Description : Multi-channel quadrature encoder front end; one independent
//               encoder_channel per channel, positions packed into value.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_bank
  import encoder_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic [1:0]                mode,
  input  logic                      saturate,
  input  logic [CHANNELS-1:0]       clear,
  input  logic [CHANNELS-1:0]       error_clr,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       error
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    encoder_channel #(
      .WIDTH         (WIDTH),
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_channel (
      .clk       (clk),
      .reset_n   (reset_n),
      .a         (a[i]),
      .b         (b[i]),
      .mode      (mode),
      .saturate  (saturate),
      .clear     (clear[i]),
      .error_clr (error_clr[i]),
      .value     (value[i*WIDTH +: WIDTH]),
      .step      (step[i]),
      .dir       (dir[i]),
      .error     (error[i])
    );
  end

endmodule : encoder_bank
`default_nettype wire

// File: tb/tb_encoder_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_bank
// Description : Directed self-checking bench for encoder_bank at default
//               parameters (3 channels, 8-bit, 2 sync stages, 3-cycle filter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_bank;

  localparam int CHANNELS = 3;
  localparam int WIDTH    = 8;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [CHANNELS-1:0]       a, b, clear, error_clr;
  logic [1:0]                mode;
  logic                      saturate;
  logic [CHANNELS*WIDTH-1:0] value;
  logic [CHANNELS-1:0]       step, dir, error;

  int checks = 0;
  int errors = 0;
  int step_cnt [CHANNELS];

  encoder_bank #(
    .CHANNELS(CHANNELS), .WIDTH(WIDTH), .SYNC_STAGES(2), .FILTER_CYCLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .mode(mode),
    .saturate(saturate), .clear(clear), .error_clr(error_clr),
    .value(value), .step(step), .dir(dir), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic hold(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CHANNELS; c++) if (step[c]) step_cnt[c]++;
    end
  endtask

  task automatic clr_steps();
    for (int c = 0; c < CHANNELS; c++) step_cnt[c] = 0;
  endtask

  task automatic pins(input int ch, input logic [1:0] ab);
    a[ch] = ab[1];
    b[ch] = ab[0];
  endtask

  function automatic logic [WIDTH-1:0] val(input int ch);
    return value[ch*WIDTH +: WIDTH];
  endfunction

  initial begin
    reset_n = 1'b0; a = '0; b = '0; clear = '0; error_clr = '0;
    mode = 2'b10; saturate = 1'b0;
    clr_steps();
    pins(0, 2'b11);
    hold(4);
    chk("reset_value", 32'(value), 32'd0);
    chk("reset_flags", 32'({step, dir, error}), 32'd0);

    // Release with ch0 idling at 11: priming must absorb it
    reset_n = 1'b1;
    hold(12);
    chk("prime_error", 32'(error), 32'd0);
    chk("prime_value", 32'(val(0)), 32'd0);
    chk("prime_steps", 32'(step_cnt[0]), 32'd0);

    // Walk ch0 to 00 in X1, where neither transition counts
    mode = 2'b00;
    pins(0, 2'b01); hold(10);
    pins(0, 2'b00); hold(10);
    chk("x1_nocount_value", 32'(val(0)), 32'd0);
    chk("x1_nocount_error", 32'(error[0]), 32'd0);

    // X4 full up cycle, first update exactly 6 clocks after the edge
    mode = 2'b10; clr_steps();
    pins(0, 2'b10); hold(5);
    chk("x4_latency_before", 32'(val(0)), 32'd0);
    hold(1);
    chk("x4_latency_value", 32'(val(0)), 32'd1);
    chk("x4_latency_step", 32'(step[0]), 32'd1);
    hold(1);
    chk("x4_step_one_cycle", 32'(step[0]), 32'd0);
    hold(3);
    pins(0, 2'b11); hold(10);
    pins(0, 2'b01); hold(10);
    pins(0, 2'b00); hold(10);
    chk("x4_value", 32'(val(0)), 32'd4);
    chk("x4_steps", 32'(step_cnt[0]), 32'd4);
    chk("x4_dir", 32'(dir[0]), 32'd1);

    // X1 down cycle from 0 wraps to 255
    clear[0] = 1'b1; hold(1); clear[0] = 1'b0;
    chk("clear_ch0", 32'(val(0)), 32'd0);
    mode = 2'b00; clr_steps();
    pins(0, 2'b01); hold(10);
    pins(0, 2'b11); hold(10);
    pins(0, 2'b10); hold(10);
    pins(0, 2'b00); hold(10);
    chk("x1_wrap_value", 32'(val(0)), 32'd255);
    chk("x1_wrap_dir", 32'(dir[0]), 32'd0);
    chk("x1_wrap_steps", 32'(step_cnt[0]), 32'd1);

    // X2 down cycle from 0 gives 254
    clear[0] = 1'b1; hold(1); clear[0] = 1'b0;
    mode = 2'b01; clr_steps();
    pins(0, 2'b01); hold(10);
    pins(0, 2'b11); hold(10);
    pins(0, 2'b10); hold(10);
    pins(0, 2'b00); hold(10);
    chk("x2_value", 32'(val(0)), 32'd254);
    chk("x2_steps", 32'(step_cnt[0]), 32'd2);

    // Saturate at top: 254 -> 255 -> holds 255 with a step pulse
    mode = 2'b10; saturate = 1'b1;
    pins(0, 2'b10); hold(10);
    chk("sat_reach_max", 32'(val(0)), 32'd255);
    clr_steps();
    pins(0, 2'b11); hold(10);
    chk("sat_hold_max", 32'(val(0)), 32'd255);
    chk("sat_max_step", 32'(step_cnt[0]), 32'd1);
    chk("sat_max_dir", 32'(dir[0]), 32'd1);

    // Saturate at bottom
    clear[0] = 1'b1; hold(1); clear[0] = 1'b0;
    clr_steps();
    pins(0, 2'b10); hold(10);
    chk("sat_hold_zero", 32'(val(0)), 32'd0);
    chk("sat_zero_step", 32'(step_cnt[0]), 32'd1);
    chk("sat_zero_dir", 32'(dir[0]), 32'd0);
    saturate = 1'b0;

    // ch1: 2-cycle glitch rejected
    clr_steps();
    a[1] = 1'b1; hold(2); a[1] = 1'b0; hold(10);
    chk("glitch_value", 32'(val(1)), 32'd0);
    chk("glitch_steps", 32'(step_cnt[1]), 32'd0);

    // ch1: illegal 00 -> 11
    pins(1, 2'b11); hold(10);
    chk("illegal_error", 32'(error[1]), 32'd1);
    chk("illegal_value", 32'(val(1)), 32'd0);
    chk("illegal_steps", 32'(step_cnt[1]), 32'd0);

    // ch1: error_clr coincides with second illegal jump 11 -> 00
    pins(1, 2'b00); hold(5);
    error_clr[1] = 1'b1; hold(1); error_clr[1] = 1'b0;
    chk("illegal_beats_clr", 32'(error[1]), 32'd1);
    hold(5);
    error_clr[1] = 1'b1; hold(1); error_clr[1] = 1'b0;
    chk("error_clr_alone", 32'(error[1]), 32'd0);

    // ch2: clear coincides with a counted up step
    clr_steps();
    pins(2, 2'b10); hold(10);
    chk("ch2_first_up", 32'(val(2)), 32'd1);
    pins(2, 2'b11); hold(5);
    clear[2] = 1'b1; hold(1); clear[2] = 1'b0;
    chk("clear_beats_step_val", 32'(val(2)), 32'd0);
    chk("clear_beats_step_stp", 32'(step[2]), 32'd1);
    chk("clear_beats_step_dir", 32'(dir[2]), 32'd1);
    hold(4);

    // Channel isolation
    chk("iso_ch0_value", 32'(val(0)), 32'd0);
    chk("iso_ch0_error", 32'(error[0]), 32'd0);
    chk("iso_ch1_value", 32'(val(1)), 32'd0);
    chk("iso_ch2_error", 32'(error[2]), 32'd0);

    // Asynchronous reset mid-operation
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_dir", 32'(dir), 32'd0);
    chk("async_reset_all", 32'({value, step, error}), 32'd0);
    hold(2);
    reset_n = 1'b1;
    hold(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_encoder_bank
`default_nettype wire
